// File: rtl/status_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : status_fifo
// Purpose  : Show-ahead synchronous FIFO of arbitrary depth with occupancy,
//            almost-full/almost-empty thresholds and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module status_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int AFULL  = DEPTH - 2,
    parameter int AEMPTY = 2,
    parameter int PTRWID = $clog2(DEPTH),
    parameter int CNTWID = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              clr_err,
    output logic [WIDTH-1:0]  data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNTWID-1:0] count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTRWID-1:0] c_last_ptr = PTRWID'(DEPTH - 1);
    localparam logic [PTRWID-1:0] c_ptr_one  = PTRWID'(1);
    localparam logic [CNTWID-1:0] c_depth    = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] c_cnt_one  = CNTWID'(1);
    localparam logic [CNTWID-1:0] c_afull    = CNTWID'(AFULL);
    localparam logic [CNTWID-1:0] c_aempty   = CNTWID'(AEMPTY);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTRWID-1:0] r_wr_ptr;
    logic [PTRWID-1:0] r_rd_ptr;
    logic [CNTWID-1:0] r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;
    logic w_ovf_event;
    logic w_udf_event;

    assign w_full  = (r_count == c_depth);
    assign w_empty = (r_count == '0);

    // A push into a full FIFO is still accepted when a pop frees the head slot.
    assign w_do_push   = push & (~w_full | pop);
    assign w_do_pop    = pop & ~w_empty;
    assign w_ovf_event = push & w_full & ~pop;
    assign w_udf_event = pop & w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
            // An error in the same cycle as the clear keeps its flag set.
            r_overflow  <= (clr_err ? 1'b0 : r_overflow)  | w_ovf_event;
            r_underflow <= (clr_err ? 1'b0 : r_underflow) | w_udf_event;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !rst) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    assign data_out     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_afull);
    assign almost_empty = (r_count <= c_aempty);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_status_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_status_fifo
// Purpose  : Directed self-checking bench for status_fifo at DEPTH=5 and 8.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_fifo;

    logic       clk;
    logic       rst;

    logic       a_push, a_pop, a_clr;
    logic [7:0] a_din, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [2:0] a_count;

    logic       b_push, b_pop, b_clr;
    logic [7:0] b_din, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [3:0] b_count;

    int n_tests = 0;
    int n_fail  = 0;

    status_fifo #(.WIDTH(8), .DEPTH(5)) u_fifo5 (
        .clk(clk), .rst(rst), .push(a_push), .pop(a_pop), .data_in(a_din),
        .clr_err(a_clr), .data_out(a_dout), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf)
    );

    status_fifo #(.WIDTH(8), .DEPTH(8), .AFULL(6), .AEMPTY(2)) u_fifo8 (
        .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .data_in(b_din),
        .clr_err(b_clr), .data_out(b_dout), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input logic p, input logic q, input logic [7:0] d, input logic c);
        a_push = p; a_pop = q; a_din = d; a_clr = c;
        tick();
        a_push = 1'b0; a_pop = 1'b0; a_clr = 1'b0;
    endtask

    task automatic b_op(input logic p, input logic q, input logic [7:0] d);
        b_push = p; b_pop = q; b_din = d;
        tick();
        b_push = 1'b0; b_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_push = 0; a_pop = 0; a_clr = 0; a_din = '0;
        b_push = 0; b_pop = 0; b_clr = 0; b_din = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_count", 32'(a_count), 0);
        check("rst_empty", 32'(a_empty), 1);
        check("rst_full",  32'(a_full),  0);
        check("rst_ovf",   32'(a_ovf),   0);
        check("rst_udf",   32'(a_udf),   0);
        check("rst_dout",  32'(a_dout),  0);
        check("rst_ae",    32'(a_ae),    1);
        check("rst_af",    32'(a_af),    0);

        // Fill DEPTH=5, no-bubble show-ahead
        for (int i = 0; i < 5; i++) begin
            a_op(1, 0, 8'h11 + 8'(i), 0);
            check("fill_count", 32'(a_count), 32'(i + 1));
            check("fill_head",  32'(a_dout), 32'h11);
        end
        check("fill_full", 32'(a_full), 1);

        for (int i = 0; i < 5; i++) begin
            check("drain_data", 32'(a_dout), 32'h11 + 32'(i));
            a_op(0, 1, 8'h00, 0);
        end
        check("drain_empty", 32'(a_empty), 1);
        check("drain_dout",  32'(a_dout),  0);
        check("drain_ovf",   32'(a_ovf),   0);
        check("drain_udf",   32'(a_udf),   0);

        // Wrap-around with simultaneous push/pop
        a_op(1, 0, 8'h20, 0);
        for (int i = 0; i < 13; i++) begin
            check("wrap_data", 32'(a_dout), 32'h20 + 32'(i));
            a_op(1, 1, 8'h21 + 8'(i), 0);
            check("wrap_count", 32'(a_count), 1);
        end
        check("wrap_last", 32'(a_dout), 32'h2D);
        a_op(0, 1, 8'h00, 0);
        check("wrap_empty", 32'(a_empty), 1);

        // Full boundary
        for (int i = 0; i < 5; i++) a_op(1, 0, 8'h31 + 8'(i), 0);
        a_op(1, 0, 8'hAA, 0);
        check("ovf_set",   32'(a_ovf),   1);
        check("ovf_count", 32'(a_count), 5);
        a_op(1, 1, 8'hBB, 0);
        check("fullpp_count", 32'(a_count), 5);
        check("fullpp_udf",   32'(a_udf),   0);
        check("fullpp_ovf",   32'(a_ovf),   1);
        for (int i = 0; i < 4; i++) begin
            check("fullpp_data", 32'(a_dout), 32'h32 + 32'(i));
            a_op(0, 1, 8'h00, 0);
        end
        check("fullpp_fifth", 32'(a_dout), 32'hBB);
        a_op(0, 1, 8'h00, 0);
        check("fullpp_empty", 32'(a_empty), 1);

        // Empty boundary and sticky clear
        a_op(0, 0, 8'h00, 1);
        check("clr_ovf", 32'(a_ovf), 0);
        a_op(0, 1, 8'h00, 0);
        check("udf_set",   32'(a_udf),   1);
        check("udf_count", 32'(a_count), 0);
        a_op(1, 1, 8'h44, 0);
        check("emptypp_count", 32'(a_count), 1);
        check("emptypp_data",  32'(a_dout),  32'h44);
        a_op(0, 0, 8'h00, 1);
        check("clr_udf",  32'(a_udf), 0);
        check("clr_ovf2", 32'(a_ovf), 0);
        a_op(0, 1, 8'h00, 0);
        check("pop_last_empty", 32'(a_empty), 1);
        a_op(0, 1, 8'h00, 1);
        check("clr_vs_udf", 32'(a_udf), 1);
        a_op(0, 0, 8'h00, 1);
        check("clr_final", 32'(a_udf), 0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) a_op(1, 0, 8'h51 + 8'(i), 0);
        a_op(1, 0, 8'h5F, 0);
        a_op(0, 1, 8'h00, 0);
        a_op(0, 1, 8'h00, 0);
        check("pre_rst_count", 32'(a_count), 3);
        check("pre_rst_ovf",   32'(a_ovf),   1);
        rst = 1'b1;
        a_op(1, 0, 8'h66, 0);
        rst = 1'b0;
        check("midrst_count", 32'(a_count), 0);
        check("midrst_empty", 32'(a_empty), 1);
        check("midrst_ovf",   32'(a_ovf),   0);
        check("midrst_dout",  32'(a_dout),  0);
        a_op(0, 0, 8'h00, 0);
        check("midrst_discard", 32'(a_count), 0);
        a_op(1, 0, 8'h77, 0);
        check("postrst_data", 32'(a_dout), 32'h77);

        // Thresholds at DEPTH=8, AFULL=6, AEMPTY=2
        for (int c = 0; c < 8; c++) begin
            check("thr_fill_count", 32'(b_count), 32'(c));
            check("thr_fill_ae",    32'(b_ae), (c <= 2) ? 32'd1 : 32'd0);
            check("thr_fill_af",    32'(b_af), (c >= 6) ? 32'd1 : 32'd0);
            b_op(1, 0, 8'hB0 + 8'(c));
        end
        check("thr_full", 32'(b_full), 1);
        for (int c = 8; c >= 0; c--) begin
            check("thr_drain_count", 32'(b_count), 32'(c));
            check("thr_drain_ae",    32'(b_ae), (c <= 2) ? 32'd1 : 32'd0);
            check("thr_drain_af",    32'(b_af), (c >= 6) ? 32'd1 : 32'd0);
            if (c > 0) begin
                check("thr_drain_data", 32'(b_dout), 32'hB0 + 32'(8 - c));
                b_op(0, 1, 8'h00);
            end
        end
        check("thr_empty", 32'(b_empty), 1);
        check("thr_ovf",   32'(b_ovf),   0);
        check("thr_udf",   32'(b_udf),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/status_fifo.md
# status_fifo

Parametrised synchronous FIFO with arbitrary (non-power-of-two) depth, an occupancy count, almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the general-purpose buffering primitive between producer and consumer stages that share one clock. It replaces the power-of-two-only FIFO wherever back-pressure visibility or error detection is needed. Output data is show-ahead: the head entry is visible on `data_out` without a pop.

## Interface

Parameters:
- `WIDTH`, 8, data bits per entry.
- `DEPTH`, 8, number of entries; any integer ≥ 2.
- `AFULL`, DEPTH-2, `almost_full` asserts when count ≥ AFULL; legal range 1..DEPTH.
- `AEMPTY`, 2, `almost_empty` asserts when count ≤ AEMPTY; legal range 0..DEPTH-1.
- `PTRWID`, $clog2(DEPTH), pointer width (derived, not overridden).
- `CNTWID`, $clog2(DEPTH+1), count width (derived, not overridden).

Ports:
- `clk`  in  1  clock. Every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  write request for `data_in`.
- `pop`  in  1  read request. It consumes the current head.
- `data_in`  in  WIDTH  write data.
- `clr_err`  in  1  clears the sticky error flags.
- `data_out`  out  WIDTH  head entry. Forced to 0 while `empty`.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AFULL.
- `almost_empty`  out  1  count ≤ AEMPTY.
- `count`  out  CNTWID  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was dropped.
- `underflow`  out  1  sticky: a pop was ignored.

## Operation

- State: `wr_ptr`, `rd_ptr` (0..DEPTH-1), `count`, `overflow`, `underflow`, and storage of DEPTH × WIDTH. Storage is not reset.
- Flags `full`, `empty`, `almost_full` and `almost_empty` decode combinationally from `count`.
- Effective operations, each computed from the pre-edge state:
  - `do_push = push & (~full | pop)`
  - `do_pop = pop & ~empty`
- `do_push`: write `data_in` to `mem[wr_ptr]`. Increment `wr_ptr`. It wraps from DEPTH-1 to 0 by explicit compare, not by bit truncation.
- `do_pop`: increment `rd_ptr`, with the same wrap rule.
- `count` next value:
  - +1 for push only.
  - -1 for pop only.
  - unchanged when both or neither occur.
- Push while full together with pop: both are performed and `count` stays at DEPTH. No overflow.
- Push while full without pop: the data is dropped, pointers and count are unchanged, and `overflow` is set.
- Pop while empty: it is ignored and `underflow` is set. If a push arrives in the same cycle, the push is performed and `count` becomes 1.
- `clr_err` clears both sticky flags. If an error event occurs in the same cycle as `clr_err`, the flag stays set.
- Reset (wins over all other inputs, including mid-operation): pointers = 0, `count` = 0, error flags = 0. Any push or pop in the reset cycle is discarded.

## Timing

- Reset values of the outputs:
  - `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0, `underflow` = 0, `data_out` = 0.
  - `almost_empty` = 1 (AEMPTY ≥ 0).
  - `almost_full` = 0, unless AFULL == 0, which is illegal.
- Write-to-read latency: data pushed at edge N appears on `data_out` after edge N when the FIFO was empty. There is no bubble.
- `data_out` is a combinational read of `mem[rd_ptr]`, gated to 0 by `empty`.
- All status outputs reflect the post-edge state in the same cycle. There is no extra flag latency.
- A pop at edge N presents the next entry on `data_out` after edge N.
- No combinational path exists from `push` or `pop` to any output.

## Test plan

- Reset, then DEPTH=5 (non-power-of-two): push 0x11..0x15 on 5 consecutive cycles, then pop 5 times.
  - After the pushes: `full` = 1 and `count` = 5.
  - During the pops: `data_out` reads 0x11..0x15 in order.
  - After the pops: `empty` = 1, `data_out` = 0, and no error flag is set.
- Wrap-around at DEPTH=5: run 13 cycles of simultaneous push/pop after one pre-push.
  - `count` holds at 1.
  - Output order matches input order across the pointer wrap.
- Full boundary: at DEPTH=5 with the FIFO full, push 0xAA alone → `overflow` = 1 and `count` = 5; 0xAA is never observed.
  - Then push+pop together: no new error, `count` = 5, and the new data emerges fifth.
- Empty boundary: pop while empty → `underflow` = 1. Then push+pop together while empty → `count` = 1.
  - Assert `clr_err` → both flags are 0 on the next cycle.
  - Assert `clr_err` in the same cycle as an empty pop → `underflow` remains 1.
- Thresholds at DEPTH=8, AFULL=6, AEMPTY=2: fill one entry per cycle.
  - `almost_empty` is 1 for counts 0..2.
  - `almost_full` rises exactly when `count` reaches 6.
  - Both track correctly while draining.
- Reset mid-operation: with `count` = 3 and `overflow` = 1, assert `rst` together with push → next cycle `count` = 0, `empty` = 1, `overflow` = 0, and the pushed data is discarded.
